eth_rx_fcs_check: RTL and testbench

- Receive-side counterpart of the TX CRC32 generator in the UDP stack.
- Takes the GMII-style byte stream from the PHY side and locates preamble/SFD.
- Runs Ethernet CRC32 over every byte after the SFD, FCS included, and checks the residue.
- Forwards the frame with the FCS stripped to the MAC RX parser, then reports good/bad at end of frame.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/crc32_d8_next.sv | 20 ++
 rtl/eth_rx_fcs_check.sv | 193 +++++++++++++++++++
 tb/tb_eth_rx_fcs_check.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and RX framing state encoding.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    // IEEE 802.3 generator polynomial, non-reflected form.
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

    // Depth of the FCS strip delay line.
    localparam int          FCS_BYTES     = 4;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        BODY,
        DROP
    } rx_state_e;

endpackage

// File: rtl/crc32_d8_next.sv
// Combinational next-state of the Ethernet CRC32 register for one byte.
// Register is non-reflected (bit 31 shifts out), data bits enter LSB first.
module crc32_d8_next
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Eight serial LFSR steps unrolled into one combinational stage.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            crc_next = {crc_next[30:0], 1'b0}
                     ^ ({32{crc_next[31] ^ data[i]}} & CRC32_POLY);
        end
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII-style receive FCS checker: finds preamble/SFD, runs CRC32 over every
// body byte (FCS included), forwards the body with the last four bytes
// stripped and reports good/bad on a one-cycle frame_done pulse.
// Optional build macro ETH_RX_FCS_STATS_EN adds saturating good/bad frame
// counters with a synchronous clear input.
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter logic [31:0] CRC_RESIDUE   = CRC32_RESIDUE,
    parameter int          MIN_FRAME_LEN = 64,
    parameter int          MAX_FRAME_LEN = 1518,
    parameter int          LEN_W         = 11
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_data,
`ifdef ETH_RX_FCS_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
`endif
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        crc_err
);

    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    rx_state_e               state;
    rx_state_e               state_nxt;

    logic [31:0]             crc_q;
    logic [31:0]             crc_upd;
    logic [LEN_W-1:0]        byte_cnt;
    int                      frame_len;
    logic                    err_flag;

    // dly[0] is the newest byte, dly[3] the oldest once the line is full.
    logic [3:0][7:0]         dly;
    logic [2:0]              dly_cnt;
    logic [7:0]              hold;
    logic                    hold_vld;
    logic                    sof_pend;

    logic                    sfd_hit;
    logic                    body_byte;
    logic                    body_end;
    logic                    emit;
    logic                    frame_good;

    crc32_d8_next u_crc (
        .crc      (crc_q),
        .data     (rx_data),
        .crc_next (crc_upd)
    );

    // Framing state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        state_nxt = state;
        sfd_hit   = 1'b0;
        body_byte = 1'b0;
        body_end  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv)
                    state_nxt = (rx_data == ETH_PREAMBLE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_nxt = IDLE;
                end else if (rx_data == ETH_SFD) begin
                    state_nxt = BODY;
                    sfd_hit   = 1'b1;
                end else if (rx_data != ETH_PREAMBLE) begin
                    state_nxt = DROP;
                end
            end
            BODY: begin
                if (rx_dv) begin
                    body_byte = 1'b1;
                end else begin
                    body_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (!rx_dv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The hold byte leaves on the next body byte or on the end of frame.
    assign emit      = hold_vld && (body_byte || body_end);

    // Length limits are compared as signed ints so a zero minimum is legal.
    assign frame_len = int'(byte_cnt);
    assign frame_good = (crc_q == CRC_RESIDUE)
                     && (frame_len > FCS_BYTES)
                     && (frame_len >= MIN_FRAME_LEN)
                     && (frame_len <= MAX_FRAME_LEN)
                     && !err_flag;

    // CRC, length, error flag and the FCS strip delay line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q    <= CRC32_INIT;
            byte_cnt <= '0;
            err_flag <= 1'b0;
            dly      <= '0;
            dly_cnt  <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            sof_pend <= 1'b0;
        end else if (sfd_hit) begin
            crc_q    <= CRC32_INIT;
            byte_cnt <= '0;
            err_flag <= 1'b0;
            dly_cnt  <= '0;
            hold_vld <= 1'b0;
            sof_pend <= 1'b1;
        end else if (body_byte) begin
            crc_q <= crc_upd;
            if (byte_cnt != LEN_SAT) byte_cnt <= byte_cnt + 1'b1;
            if (rx_er) err_flag <= 1'b1;
            dly <= {dly[2:0], rx_data};
            if (dly_cnt == 3'(FCS_BYTES)) begin
                hold     <= dly[3];
                hold_vld <= 1'b1;
            end else begin
                dly_cnt  <= dly_cnt + 1'b1;
            end
            if (hold_vld) sof_pend <= 1'b0;
        end else if (body_end) begin
            hold_vld <= 1'b0;
            sof_pend <= 1'b0;
        end
    end

    // Registered payload stream and end-of-frame status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
        end else begin
            out_valid  <= emit;
            out_sof    <= emit && sof_pend;
            out_eof    <= emit && body_end;
            if (emit) out_data <= hold;
            frame_done <= body_end;
            crc_ok     <= body_end && frame_good;
            crc_err    <= body_end && !frame_good;
        end
    end

`ifdef ETH_RX_FCS_STATS_EN
    // Saturating frame counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (stats_clr) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (frame_done && crc_ok && good_cnt != 16'hFFFF)
                good_cnt <= good_cnt + 1'b1;
            if (frame_done && crc_err && bad_cnt != 16'hFFFF)
                bad_cnt <= bad_cnt + 1'b1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check. Two instances share the input stream: one
// with MIN_FRAME_LEN=0 and one with default limits. Expected outputs come
// from a reflected table-free CRC32 reference and the payload stream rule.
module tb_eth_rx_fcs_check;

    logic       clk;
    logic       reset_n;
    logic       rx_dv;
    logic       rx_er;
    logic [7:0] rx_data;

    logic       o0_valid, o0_sof, o0_eof, o0_done, o0_ok, o0_err;
    logic [7:0] o0_data;
    logic       o1_valid, o1_sof, o1_eof, o1_done, o1_ok, o1_err;
    logic [7:0] o1_data;

`ifdef ETH_RX_FCS_STATS_EN
    logic        stats_clr;
    logic [15:0] g0_cnt, b0_cnt, g1_cnt, b1_cnt;
    int          mg0, mb0, mg1, mb1;
`endif

    eth_rx_fcs_check #(.MIN_FRAME_LEN(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
`ifdef ETH_RX_FCS_STATS_EN
        .stats_clr(stats_clr), .good_cnt(g0_cnt), .bad_cnt(b0_cnt),
`endif
        .out_valid(o0_valid), .out_data(o0_data), .out_sof(o0_sof), .out_eof(o0_eof),
        .frame_done(o0_done), .crc_ok(o0_ok), .crc_err(o0_err)
    );

    eth_rx_fcs_check u_dut1 (
        .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
`ifdef ETH_RX_FCS_STATS_EN
        .stats_clr(stats_clr), .good_cnt(g1_cnt), .bad_cnt(b1_cnt),
`endif
        .out_valid(o1_valid), .out_data(o1_data), .out_sof(o1_sof), .out_eof(o1_eof),
        .frame_done(o1_done), .crc_ok(o1_ok), .crc_err(o1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       done;
        logic       ok0;
        logic       ok1;
    } exp_t;

    typedef struct {
        int         pay_len;
        int         total;     // -1: keep whole frame, else truncate body
        logic [7:0] sfd;
        int         flip_idx;  // -1: no byte replaced
        logic [7:0] flip_val;
        int         er_idx;    // -1: no rx_er
        int         exp0;      // -1: use reference model
        int         exp1;
    } vec_t;

    exp_t       pend;
    logic [7:0] cur_data;
    int         n_vec;
    int         n_err;

    function automatic exp_t quiet();
        exp_t e;
        e = '{default: '0};
        e.data = cur_data;
        return e;
    endfunction

    function automatic exp_t beat(input logic [7:0] d, input logic sof, input logic eof);
        exp_t e;
        e = '{default: '0};
        e.valid = 1'b1;
        e.data  = d;
        e.sof   = sof;
        e.eof   = eof;
        cur_data = d;
        return e;
    endfunction

    // Reflected CRC-32 (poly EDB88320) with final inversion, as transmitted.
    function automatic logic [31:0] crc_ref(input logic [7:0] q[$], input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic model_ok(input logic [7:0] q[$], input int er_idx, input int min_len);
        int n;
        logic [31:0] fcs;
        n = q.size();
        if (n < 5 || n < min_len || n > 1518) return 1'b0;
        if (er_idx >= 0 && er_idx < n) return 1'b0;
        fcs = {q[n-1], q[n-2], q[n-3], q[n-4]};
        return crc_ref(q, n - 4) == fcs;
    endfunction

    task automatic check();
        logic [13:0] x0, x1, a0, a1;
        x0 = {pend.valid, pend.data, pend.sof, pend.eof, pend.done,
              pend.done & pend.ok0, pend.done & ~pend.ok0};
        x1 = {pend.valid, pend.data, pend.sof, pend.eof, pend.done,
              pend.done & pend.ok1, pend.done & ~pend.ok1};
        a0 = {o0_valid, o0_data, o0_sof, o0_eof, o0_done, o0_ok, o0_err};
        a1 = {o1_valid, o1_data, o1_sof, o1_eof, o1_done, o1_ok, o1_err};
        n_vec += 2;
        if (a0 !== x0) begin
            n_err++;
            $display("FAIL dut0_out t=%0t v/data/sof/eof/done/ok/err got %b required %b", $time, a0, x0);
        end
        if (a1 !== x1) begin
            n_err++;
            $display("FAIL dut1_out t=%0t v/data/sof/eof/done/ok/err got %b required %b", $time, a1, x1);
        end
    endtask

    // Check the outputs produced by the previous cycle, then drive this one.
    task automatic step(input logic dv, input logic er, input logic [7:0] d, input exp_t e);
        @(negedge clk);
        check();
        rx_dv   = dv;
        rx_er   = er;
        rx_data = d;
        pend    = e;
    endtask

    task automatic run_frame(input int pre_len, input logic [7:0] sfd, input logic [7:0] q[$],
                             input int er_idx, input int gap, input int exp0, input int exp1);
        exp_t e;
        int   n;
        logic drop;
        n    = q.size();
        drop = (sfd != 8'hD5);
        for (int i = 0; i < pre_len; i++) step(1'b1, 1'b0, 8'h55, quiet());
        step(1'b1, 1'b0, sfd, quiet());
        for (int k = 1; k <= n; k++) begin
            e = quiet();
            if (!drop && k >= 6) e = beat(q[k-6], k == 6, 1'b0);
            step(1'b1, (k - 1 == er_idx), q[k-1], e);
        end
        e = quiet();
        if (!drop) begin
            if (n >= 5) e = beat(q[n-5], n == 5, 1'b1);
            e.done = 1'b1;
            e.ok0  = (exp0 >= 0) ? exp0[0] : model_ok(q, er_idx, 0);
            e.ok1  = (exp1 >= 0) ? exp1[0] : model_ok(q, er_idx, 64);
`ifdef ETH_RX_FCS_STATS_EN
            if (e.ok0) mg0++; else mb0++;
            if (e.ok1) mg1++; else mb1++;
`endif
        end
        step(1'b0, 1'b0, 8'($urandom), e);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom), quiet());
    endtask

    task automatic build(input vec_t v, output logic [7:0] q[$]);
        logic [31:0] c;
        q.delete();
        for (int i = 0; i < v.pay_len; i++) q.push_back(8'h31 + 8'(i));
        c = crc_ref(q, q.size());
        for (int j = 0; j < 4; j++) q.push_back(c[8*j +: 8]);
        if (v.flip_idx >= 0) q[v.flip_idx] = v.flip_val;
        if (v.total >= 0) while (q.size() > v.total) void'(q.pop_back());
    endtask

    vec_t       tbl[12];
    logic [7:0] q[$];

    initial begin
        // pay_len total sfd flip_idx flip_val er_idx exp0 exp1
        tbl[0]  = '{9,    -1, 8'hD5, -1, 8'h00, -1,  1,  0}; // "123456789" good, runt for dut1
        tbl[1]  = '{9,    -1, 8'hD5,  4, 8'h34, -1,  0,  0}; // 0x35 -> 0x34
        tbl[2]  = '{9,    -1, 8'hD5, -1, 8'h00,  2,  0,  0}; // rx_er on 3rd body byte
        tbl[3]  = '{9,    -1, 8'h5A, -1, 8'h00, -1,  0,  0}; // bad SFD: dropped
        tbl[4]  = '{9,    -1, 8'hD5, -1, 8'h00, -1,  1,  0}; // good after drop
        tbl[5]  = '{1,    -1, 8'hD5, -1, 8'h00, -1,  1,  0}; // N=5, single byte sof+eof
        tbl[6]  = '{0,    -1, 8'hD5, -1, 8'h00, -1,  0,  0}; // N=4, no payload
        tbl[7]  = '{0,     0, 8'hD5, -1, 8'h00, -1,  0,  0}; // N=0
        tbl[8]  = '{60,   -1, 8'hD5, -1, 8'h00, -1,  1,  1}; // N=64
        tbl[9]  = '{59,   -1, 8'hD5, -1, 8'h00, -1,  1,  0}; // N=63
        tbl[10] = '{1514, -1, 8'hD5, -1, 8'h00, -1,  1,  1}; // N=1518
        tbl[11] = '{1515, -1, 8'hD5, -1, 8'h00, -1,  0,  0}; // N=1519

        n_vec    = 0;
        n_err    = 0;
        cur_data = 8'h00;
        reset_n  = 1'b0;
        rx_dv    = 1'b0;
        rx_er    = 1'b0;
        rx_data  = 8'h00;
        pend     = quiet();
`ifdef ETH_RX_FCS_STATS_EN
        stats_clr = 1'b0;
        mg0 = 0; mb0 = 0; mg1 = 0; mb1 = 0;
`endif
        step(1'b0, 1'b0, 8'h00, quiet());
        step(1'b0, 1'b0, 8'h00, quiet());
        reset_n = 1'b1;
        step(1'b0, 1'b0, 8'h00, quiet());

        // Directed table.
        for (int t = 0; t < 12; t++) begin
            build(tbl[t], q);
            run_frame(7, tbl[t].sfd, q, tbl[t].er_idx, 1, tbl[t].exp0, tbl[t].exp1);
        end

        // Randomized frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            int          plen;
            int          r;
            int          er;
            logic [7:0]  sf;
            logic [31:0] c;
            r = int'($urandom_range(0, 9));
            if (r == 0)      plen = int'($urandom_range(0, 3));
            else if (r < 3)  plen = int'($urandom_range(56, 64));
            else             plen = int'($urandom_range(4, 40));
            q.delete();
            for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
            c = crc_ref(q, q.size());
            for (int j = 0; j < 4; j++) q.push_back(c[8*j +: 8]);
            if ($urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, q.size() - 1));
                q[r] = q[r] ^ 8'($urandom_range(1, 255));
            end
            er = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
            sf = ($urandom_range(0, 9) == 0) ? 8'h5A : 8'hD5;
            run_frame(int'($urandom_range(1, 7)), sf, q, er, int'($urandom_range(0, 2)), -1, -1);
        end

        // Back-to-back: next preamble sampled in the frame_done cycle.
        build(tbl[0], q);
        run_frame(7, 8'hD5, q, -1, 0, 1, 0);
        run_frame(7, 8'hD5, q, -1, 1, 1, 0);

        // Length counter saturation: 2118 bytes, correct FCS, must fail.
        q.delete();
        for (int i = 0; i < 2114; i++) q.push_back(8'($urandom));
        begin
            logic [31:0] c;
            c = crc_ref(q, q.size());
            for (int j = 0; j < 4; j++) q.push_back(c[8*j +: 8]);
        end
        run_frame(3, 8'hD5, q, -1, 1, 0, 0);

        // Reset mid-body, then a good frame.
        build(tbl[0], q);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h55, quiet());
        step(1'b1, 1'b0, 8'hD5, quiet());
        for (int k = 1; k <= 8; k++) begin
            exp_t e;
            e = quiet();
            if (k >= 6) e = beat(q[k-6], k == 6, 1'b0);
            step(1'b1, 1'b0, q[k-1], e);
        end
        @(negedge clk);
        check();
        reset_n  = 1'b0;
        cur_data = 8'h00;
        rx_data  = q[8];
        pend     = quiet();
`ifdef ETH_RX_FCS_STATS_EN
        mg0 = 0; mb0 = 0; mg1 = 0; mb1 = 0;
`endif
        step(1'b1, 1'b0, q[9], quiet());
        @(negedge clk);
        check();
        reset_n = 1'b1;
        rx_data = q[10];
        pend    = quiet();
        step(1'b1, 1'b0, q[11], quiet());
        step(1'b1, 1'b0, q[12], quiet());
        step(1'b0, 1'b0, 8'h00, quiet());
        run_frame(7, 8'hD5, q, -1, 3, 1, 0);
        @(negedge clk);
        check();

`ifdef ETH_RX_FCS_STATS_EN
        n_vec += 4;
        if (g0_cnt !== 16'(mg0)) begin n_err++; $display("FAIL good_cnt0 got %0d required %0d", g0_cnt, mg0); end
        if (b0_cnt !== 16'(mb0)) begin n_err++; $display("FAIL bad_cnt0 got %0d required %0d", b0_cnt, mb0); end
        if (g1_cnt !== 16'(mg1)) begin n_err++; $display("FAIL good_cnt1 got %0d required %0d", g1_cnt, mg1); end
        if (b1_cnt !== 16'(mb1)) begin n_err++; $display("FAIL bad_cnt1 got %0d required %0d", b1_cnt, mb1); end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
